// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer: locks on the frame marker and publishes a..d per frame.
// Optional misplaced-marker check and resync is enabled by defining TDM_SYNC_CHECK_EN.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic             frame_valid,
   output logic             locked,
   output logic [1:0]       slot,
   output logic             sync_err
);

   typedef enum logic [0:0] {StHunt, StLocked} state_e;

   state_e           state_q, state_d;
   logic [1:0]       slot_q, slot_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic [WIDTH-1:0] sh_c_q, sh_c_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             fv_q, fv_d;
   logic             serr_q, serr_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StHunt;
         slot_q  <= 2'd0;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         sh_c_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         fv_q    <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         sh_a_q  <= sh_a_d;
         sh_b_q  <= sh_b_d;
         sh_c_q  <= sh_c_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         fv_q    <= fv_d;
         serr_q  <= serr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      sh_a_d  = sh_a_q;
      sh_b_d  = sh_b_q;
      sh_c_d  = sh_c_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      fv_d    = 1'b0;
      serr_d  = 1'b0;

      if (din_valid) begin
         unique case (state_q)
            StHunt: begin
               if (sync) begin
                  sh_a_d  = din;
                  slot_d  = 2'd1;
                  state_d = StLocked;
               end
            end
            StLocked: begin
`ifdef TDM_SYNC_CHECK_EN
               if (sync && (slot_q != 2'd0)) begin
                  // Resync: drop the partial frame and treat this beat as slot 0.
                  serr_d = 1'b1;
                  sh_a_d = din;
                  slot_d = 2'd1;
               end else begin
`else
               begin
`endif
                  slot_d = slot_q + 2'd1;
                  unique case (slot_q)
                     2'd0: sh_a_d = din;
                     2'd1: sh_b_d = din;
                     2'd2: sh_c_d = din;
                     2'd3: begin
                        a_d  = sh_a_q;
                        b_d  = sh_b_q;
                        c_d  = sh_c_q;
                        d_d  = din;
                        fv_d = 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   assign a           = a_q;
   assign b           = b_q;
   assign c           = c_q;
   assign d           = d_q;
   assign frame_valid = fv_q;
   assign locked      = (state_q == StLocked);
   assign slot        = slot_q;
   assign sync_err    = serr_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Table-driven bench for tdm_demux4 (WIDTH=4); each row is one clock of stimulus plus the
// expected registered outputs after that edge.
module tb_tdm_demux4;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         sync;
   logic [W-1:0] a, b, c, d;
   logic         frame_valid;
   logic         locked;
   logic [1:0]   slot;
   logic         sync_err;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .frame_valid(frame_valid),
      .locked     (locked),
      .slot       (slot),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic [W-1:0] din;
      logic         vld;
      logic         syn;
      logic [15:0]  abcd;
      logic         fv;
      logic         lk;
      logic [1:0]   sl;
      logic         se;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;
   bit   done  = 1'b0;

   task automatic row(input logic r, input logic [W-1:0] dn, input logic v, input logic s,
                      input logic [15:0] e_abcd, input logic e_fv, input logic e_lk,
                      input logic [1:0] e_sl, input logic e_se);
      vec_t t;
      t.rst = r; t.din = dn; t.vld = v; t.syn = s;
      t.abcd = e_abcd; t.fv = e_fv; t.lk = e_lk; t.sl = e_sl; t.se = e_se;
      vecs.push_back(t);
   endtask

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL: timeout waiting for table playback to finish");
         $display("test done: total=%0d bad=%0d", total, bad + 1);
         $finish;
      end
   end

   initial begin
      logic [15:0] p;
      logic [20:0] got, exp;

      // Reset held 3 cycles, then beats without a marker stay in HUNT.
      for (int i = 0; i < 3; i++) row(1, 4'h0, 0, 0, 16'h0000, 0, 0, 2'd0, 0);
      row(0, 4'h7, 1, 0, 16'h0000, 0, 0, 2'd0, 0);
      row(0, 4'h8, 1, 0, 16'h0000, 0, 0, 2'd0, 0);
      row(0, 4'h9, 1, 0, 16'h0000, 0, 0, 2'd0, 0);
      // Basic frame.
      row(0, 4'h5, 1, 1, 16'h0000, 0, 1, 2'd1, 0);
      row(0, 4'hA, 1, 0, 16'h0000, 0, 1, 2'd2, 0);
      row(0, 4'h3, 1, 0, 16'h0000, 0, 1, 2'd3, 0);
      row(0, 4'hC, 1, 0, 16'h5A3C, 1, 1, 2'd0, 0);
      row(0, 4'h0, 0, 0, 16'h5A3C, 0, 1, 2'd0, 0);
      // Frame with two idle cycles between beats; idle beats carry junk and sync.
      row(0, 4'h6, 1, 1, 16'h5A3C, 0, 1, 2'd1, 0);
      row(0, 4'hF, 0, 1, 16'h5A3C, 0, 1, 2'd1, 0);
      row(0, 4'hF, 0, 1, 16'h5A3C, 0, 1, 2'd1, 0);
      row(0, 4'h7, 1, 0, 16'h5A3C, 0, 1, 2'd2, 0);
      row(0, 4'hF, 0, 1, 16'h5A3C, 0, 1, 2'd2, 0);
      row(0, 4'hF, 0, 0, 16'h5A3C, 0, 1, 2'd2, 0);
      row(0, 4'hE, 1, 0, 16'h5A3C, 0, 1, 2'd3, 0);
      row(0, 4'hF, 0, 0, 16'h5A3C, 0, 1, 2'd3, 0);
      row(0, 4'hF, 0, 1, 16'h5A3C, 0, 1, 2'd3, 0);
      row(0, 4'h1, 1, 0, 16'h67E1, 1, 1, 2'd0, 0);
      row(0, 4'h0, 0, 0, 16'h67E1, 0, 1, 2'd0, 0);
      // Three back-to-back frames.
      row(0, 4'h1, 1, 1, 16'h67E1, 0, 1, 2'd1, 0);
      row(0, 4'h2, 1, 0, 16'h67E1, 0, 1, 2'd2, 0);
      row(0, 4'h3, 1, 0, 16'h67E1, 0, 1, 2'd3, 0);
      row(0, 4'h4, 1, 0, 16'h1234, 1, 1, 2'd0, 0);
      row(0, 4'h9, 1, 1, 16'h1234, 0, 1, 2'd1, 0);
      row(0, 4'h8, 1, 0, 16'h1234, 0, 1, 2'd2, 0);
      row(0, 4'h7, 1, 0, 16'h1234, 0, 1, 2'd3, 0);
      row(0, 4'h6, 1, 0, 16'h9876, 1, 1, 2'd0, 0);
      row(0, 4'hF, 1, 1, 16'h9876, 0, 1, 2'd1, 0);
      row(0, 4'h0, 1, 0, 16'h9876, 0, 1, 2'd2, 0);
      row(0, 4'h5, 1, 0, 16'h9876, 0, 1, 2'd3, 0);
      row(0, 4'hA, 1, 0, 16'hF05A, 1, 1, 2'd0, 0);
      // Marker on the slot-2 beat.
      row(0, 4'hB, 1, 1, 16'hF05A, 0, 1, 2'd1, 0);
      row(0, 4'hD, 1, 0, 16'hF05A, 0, 1, 2'd2, 0);
`ifdef TDM_SYNC_CHECK_EN
      row(0, 4'hE, 1, 1, 16'hF05A, 0, 1, 2'd1, 1);
      row(0, 4'h2, 1, 0, 16'hF05A, 0, 1, 2'd2, 0);
      row(0, 4'h3, 1, 0, 16'hF05A, 0, 1, 2'd3, 0);
      row(0, 4'h4, 1, 0, 16'hE234, 1, 1, 2'd0, 0);
      p = 16'hE234;
`else
      row(0, 4'hE, 1, 1, 16'hF05A, 0, 1, 2'd3, 0);
      row(0, 4'h2, 1, 0, 16'hBDE2, 1, 1, 2'd0, 0);
      row(0, 4'h3, 1, 0, 16'hBDE2, 0, 1, 2'd1, 0);
      row(0, 4'h4, 1, 0, 16'hBDE2, 0, 1, 2'd2, 0);
      row(0, 4'h5, 1, 0, 16'hBDE2, 0, 1, 2'd3, 0);
      row(0, 4'h6, 1, 0, 16'h3456, 1, 1, 2'd0, 0);
      p = 16'h3456;
`endif
      // Reset after slots 0 and 1; reset wins over a valid sync beat.
      row(0, 4'h9, 1, 1, p,        0, 1, 2'd1, 0);
      row(0, 4'h8, 1, 0, p,        0, 1, 2'd2, 0);
      row(1, 4'h7, 1, 1, 16'h0000, 0, 0, 2'd0, 0);
      row(0, 4'h3, 1, 1, 16'h0000, 0, 1, 2'd1, 0);
      row(0, 4'hC, 1, 0, 16'h0000, 0, 1, 2'd2, 0);
      row(0, 4'h5, 1, 0, 16'h0000, 0, 1, 2'd3, 0);
      row(0, 4'h1, 1, 0, 16'h3C51, 1, 1, 2'd0, 0);
      row(0, 4'h0, 0, 0, 16'h3C51, 0, 1, 2'd0, 0);

      rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         rst       = vecs[i].rst;
         din       = vecs[i].din;
         din_valid = vecs[i].vld;
         sync      = vecs[i].syn;
         @(posedge clk);
         #1;
         got = {a, b, c, d, frame_valid, locked, slot, sync_err};
         exp = {vecs[i].abcd, vecs[i].fv, vecs[i].lk, vecs[i].sl, vecs[i].se};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL row%0d: got abcd=%h fv=%b lk=%b slot=%0d serr=%b, want abcd=%h fv=%b lk=%b slot=%0d serr=%b",
                     i, got[20:5], got[4], got[3], got[2:1], got[0],
                     exp[20:5], exp[4], exp[3], exp[2:1], exp[0]);
         end
         if (i == 2) begin
            total++;
            if ({a, b, c, d, frame_valid, locked, slot, sync_err} !== 21'd0) begin
               bad++;
               $display("FAIL reset state: abcd=%h fv=%b lk=%b slot=%0d serr=%b",
                        {a, b, c, d}, frame_valid, locked, slot, sync_err);
            end
         end
      end

      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Time-division demultiplexer for the 4:1 channel path: the receive end of a link whose transmit end walks the 4:1 mux select through slots 0..3 and puts one channel per clock on a single line. `tdm_demux4` locks onto the frame marker, counts slots, and routes each beat to one of four channel registers `a`, `b`, `c`, `d`. It publishes all four together once per complete frame. It sits directly after the serial line and feeds the parallel-channel consumers.

## Interface
- `WIDTH`, default 1: bits per channel and per line beat.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `din`  in  WIDTH  line data, one slot per valid beat.
- `din_valid`  in  1  beat qualifier; no slot advance when low.
- `sync`  in  1  frame marker, high on the slot-0 beat only; ignored unless `din_valid`.
- `a`, `b`, `c`, `d`  out  WIDTH each  channel outputs for slots 0, 1, 2, 3.
- `frame_valid`  out  1  one-cycle pulse when `a`..`d` take a new frame.
- `locked`  out  1  high in LOCKED state.
- `slot`  out  2  next expected slot index; 0 in HUNT.
- `sync_err`  out  1  one-cycle pulse on a misplaced marker (only with `TDM_SYNC_CHECK_EN`).

## Operation
- The design has one clock and one reset. Reset is synchronous and active-high.
- Reset values: `a`=`b`=`c`=`d`=0, `frame_valid`=0, `locked`=0, `slot`=0, `sync_err`=0. The shadow registers are cleared and the state is HUNT.
- Slot mapping is fixed: slot 0→`a`, 1→`b`, 2→`c`, 3→`d`. This matches transmit select `{s1,s0}` = slot.
- Internal shadow registers `sh_a`, `sh_b`, `sh_c` hold the slot 0..2 beats of the frame in progress.
- HUNT state:
  - Beats with `sync`=0 are discarded.
  - A beat with `din_valid`&`sync` writes `sh_a`, sets `slot`=1, and moves to LOCKED.
- LOCKED state: each valid beat writes the shadow register for the current `slot`, then `slot` increments modulo 4.
- The slot-3 beat does four things:
  - `a`←`sh_a`, `b`←`sh_b`, `c`←`sh_c`, `d`←`din`.
  - `frame_valid` pulses.
  - `slot` wraps to 0.
  - The state stays LOCKED.
- In LOCKED, `sync` high on a slot-0 beat is the normal case and causes no action.
- `din_valid` low in any state holds all state and outputs. `frame_valid` and `sync_err` are 0 in that cycle.
- `a`..`d` change only on a frame completion or on reset. A partial frame is never published.

## Timing
- All outputs are registered.
- If the slot-3 beat is sampled at edge N, `a`..`d` show the new frame and `frame_valid`=1 in the cycle after edge N, for one cycle. Latency is 1 clock.
- Back-to-back frames with `din_valid` held high give a `frame_valid` pulse every 4 cycles.
- `locked` rises in the cycle after the first valid sync beat.
- `rst` overrides everything else at the same edge. A partial frame in progress is lost and the block returns to HUNT.
- A valid `sync` beat at slot≠0 while LOCKED is handled as described in Configuration.

## Configuration
- Macro: `TDM_SYNC_CHECK_EN`.
- With the macro defined:
  - A valid beat with `sync`=1 at `slot`≠0 in LOCKED pulses `sync_err` for one cycle, registered like `frame_valid`.
  - The partial frame is discarded and `a`..`d` are not updated.
  - The beat is taken as slot 0: it writes `sh_a` and sets `slot`=1.
  - `locked` stays 1.
- Without the macro:
  - `sync` is ignored in LOCKED, and slots free-run modulo 4 from the initial lock.
  - `sync_err` is tied to 0.

## Test plan
- **Reset values:** hold `rst`=1 for 3 cycles, then release → all outputs 0 and `locked`=0. Drive 3 valid beats with `sync`=0 → `locked` stays 0 and no `frame_valid`.
- **Basic frame:** WIDTH=4, beats 0x5 (with `sync`), 0xA, 0x3, 0xC on consecutive cycles → one cycle after the 4th beat, `a`=5, `b`=A, `c`=3, `d`=C and `frame_valid`=1 for exactly one cycle.
- **Valid gaps:** same frame with `din_valid` low for 2 cycles between each beat → identical outputs. `frame_valid` asserts one cycle after the last beat and `slot` holds during the gaps.
- **Continuous stream:** 3 back-to-back frames → `frame_valid` pulses at 4-cycle spacing, with each frame's values appearing in order.
- **Misplaced marker:** with `TDM_SYNC_CHECK_EN`, raise `sync` on the slot-2 beat → `sync_err` pulses, `a`..`d` keep the prior frame, and the next 3 beats complete a frame started at that beat. Without the macro the same stimulus gives no `sync_err`, and the frame completes on the original slot alignment.
- **Reset mid-frame:** assert `rst` after slots 0 and 1 → `locked`=0 and outputs 0. The next sync-marked frame is published correctly.
